// File: rtl/pes_rr_requester.sv
// pes_rr_requester
//   Requestor-side front end for a 4-way round-robin arbiter. Each channel
//   keeps a saturating count of pending transaction tokens. Client engines
//   enqueue tokens with push pulses, and the arbiter drains them with grants.
//   The block drives req[3:0], reports consumed tokens on done, and keeps
//   sticky overflow and spurious-grant flags.
//
//   Optional feature: define RR_REQ_WATCHDOG_EN to build a per-channel
//   starvation watchdog. Without it, starve is tied to 4'b0000.
//
// Parameters
//   CNT_W     width of each pending counter; queue depth is 2**CNT_W-1
//   MAX_WAIT  number of cycles req may stay high without a grant before
//             starve is raised (watchdog builds only)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   en        1 = drive requests and accept grants; 0 = req forced low
//   push      per-channel one-cycle token enqueue
//   grant     level grant from the arbiter; may be multi-hot
//   clr_err   synchronous clear of overflow/spurious
//   req       request to arbiter: en & (pending != 0)
//   done      registered one-cycle pulse per consumed token
//   full      pending at maximum
//   overflow  sticky: push dropped because the channel was full
//   spurious  sticky: grant while enabled with nothing pending
//   starve    watchdog flag
//   io_oeb    pad output-enable, constant 0
module pes_rr_requester #(
    parameter int CNT_W    = 3,
    parameter int MAX_WAIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] push,
    input  logic [3:0] grant,
    input  logic       clr_err,
    output logic [3:0] req,
    output logic [3:0] done,
    output logic [3:0] full,
    output logic [3:0] overflow,
    output logic [3:0] spurious,
    output logic [3:0] starve,
    output logic [3:0] io_oeb
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    // IDLE is held exactly when the channel's pending count is zero.
    // SERVE marks the cycle after a grant that left tokens queued.
    typedef enum logic [1:0] {IDLE, WAIT, SERVE} ch_state_t;

    ch_state_t        state      [4];
    ch_state_t        state_next [4];
    logic [CNT_W-1:0] pending      [4];
    logic [CNT_W-1:0] pending_next [4];
    logic [3:0]       consume;
    logic [3:0]       accept;
    logic [3:0]       drop;
    logic [3:0]       stray;

    // Count update for one channel. A simultaneous push and consume leaves
    // the count unchanged: one token enters and one leaves. The accept term
    // never admits a push at MAX_CNT without a matching consume, so the
    // count cannot wrap.
    function automatic logic [CNT_W-1:0] sat_step(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        if (inc && !dec) return cur + 1'b1;
        if (dec && !inc) return cur - 1'b1;
        return cur;
    endfunction

    always_comb begin
        req     = '0;
        full    = '0;
        consume = '0;
        accept  = '0;
        drop    = '0;
        stray   = '0;
        for (int i = 0; i < 4; i++) begin
            pending_next[i] = pending[i];
            state_next[i]   = state[i];
        end
        for (int i = 0; i < 4; i++) begin
            full[i]    = (pending[i] == MAX_CNT);
            req[i]     = en & (state[i] != IDLE);
            consume[i] = en & grant[i] & (state[i] != IDLE);
            stray[i]   = en & grant[i] & (state[i] == IDLE);
            // A full channel can still take a push when a token leaves in
            // the same cycle.
            accept[i]  = push[i] & (~full[i] | consume[i]);
            drop[i]    = push[i] & full[i] & ~consume[i];
            pending_next[i] = sat_step(pending[i], accept[i], consume[i]);
            if (pending_next[i] == '0)
                state_next[i] = IDLE;
            else if (consume[i])
                state_next[i] = SERVE;
            else
                state_next[i] = WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pending[i] <= '0;
                state[i]   <= IDLE;
            end
            done     <= '0;
            overflow <= '0;
            spurious <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pending[i] <= pending_next[i];
                state[i]   <= state_next[i];
            end
            done     <= consume;
            // A set event in the same cycle takes priority over clr_err.
            overflow <= (overflow & ~{4{clr_err}}) | drop;
            spurious <= (spurious & ~{4{clr_err}}) | stray;
        end
    end

`ifdef RR_REQ_WATCHDOG_EN
    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_MAX)
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < 4; i++) starve[i] = (wait_cnt[i] == WAIT_MAX);
    end
`else
    assign starve = 4'b0000;
`endif

    assign io_oeb = 4'b0000;

endmodule

// File: tb/tb_pes_rr_requester.sv
// tb_pes_rr_requester
//   Directed bench for pes_rr_requester. Inputs change 1 time unit after a
//   rising edge. Outputs are checked before the next rising edge.
module tb_pes_rr_requester;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] push;
    logic [3:0] grant;
    logic       clr_err;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] full;
    logic [3:0] overflow;
    logic [3:0] spurious;
    logic [3:0] starve;
    logic [3:0] io_oeb;

    int total = 0;
    int bad   = 0;

`ifdef RR_REQ_WATCHDOG_EN
    localparam logic [3:0] STARVE_EXP = 4'b0001;
`else
    localparam logic [3:0] STARVE_EXP = 4'b0000;
`endif

    pes_rr_requester #(.CNT_W(3), .MAX_WAIT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .push     (push),
        .grant    (grant),
        .clr_err  (clr_err),
        .req      (req),
        .done     (done),
        .full     (full),
        .overflow (overflow),
        .spurious (spurious),
        .starve   (starve),
        .io_oeb   (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; push = '0; grant = '0; clr_err = 1'b0;
        tick();
        tick();
        chk("rst_req", req, 4'b0000);
        chk("rst_done", done, 4'b0000);
        chk("rst_full", full, 4'b0000);
        chk("rst_overflow", overflow, 4'b0000);
        chk("rst_spurious", spurious, 4'b0000);
        chk("rst_starve", starve, 4'b0000);
        chk("io_oeb", io_oeb, 4'b0000);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // Single token on channel 0. The grant arrives 3 cycles after the push.
        push = 4'b0001;
        tick();
        push = 4'b0000;
        chk("t1_req_after_push", req, 4'b0001);
        chk("t1_no_done", done, 4'b0000);
        tick();
        tick();
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        chk("t1_done", done, 4'b0001);
        chk("t1_req_low", req, 4'b0000);
        tick();
        chk("t1_done_pulse_end", done, 4'b0000);

        // Channel 2 fills at 7 tokens. The eighth push is dropped.
        for (int k = 1; k <= 8; k++) begin
            push = 4'b0100;
            tick();
            if (k == 6) chk("t2_not_full_6", full, 4'b0000);
            if (k == 7) begin
                chk("t2_full_7", full, 4'b0100);
                chk("t2_no_ovf_7", overflow, 4'b0000);
            end
        end
        push = 4'b0000;
        chk("t2_overflow", overflow, 4'b0100);
        chk("t2_full_8", full, 4'b0100);
        chk("t2_req", req, 4'b0100);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2_ovf_cleared", overflow, 4'b0000);
        chk("t2_still_full", full, 4'b0100);
        // A push while full, with a grant in the same cycle, is accepted and the count holds at 7.
        push = 4'b0100; grant = 4'b0100;
        tick();
        push = 4'b0000;
        chk("t2_full_swap_done", done, 4'b0100);
        chk("t2_full_swap_full", full, 4'b0100);
        chk("t2_full_swap_noovf", overflow, 4'b0000);
        // Seven more grant cycles drain the channel.
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) chk("t2_drain_notfull", full, 4'b0000);
            chk("t2_drain_done", done, 4'b0100);
        end
        grant = 4'b0000;
        chk("t2_drained_req", req, 4'b0000);
        chk("t2_drained_spur", spurious, 4'b0000);

        // Channel 1 holds 2 tokens. The grant is held for 3 cycles.
        push = 4'b0010;
        tick();
        tick();
        push = 4'b0000;
        chk("t3_req", req, 4'b0010);
        grant = 4'b0010;
        tick();
        chk("t3_done1", done, 4'b0010);
        chk("t3_req_still", req, 4'b0010);
        tick();
        chk("t3_done2", done, 4'b0010);
        chk("t3_req_low", req, 4'b0000);
        chk("t3_no_spur_yet", spurious, 4'b0000);
        tick();
        chk("t3_no_done3", done, 4'b0000);
        chk("t3_spurious", spurious, 4'b0010);
        // When a spurious grant coincides with clr_err, the set wins.
        clr_err = 1'b1;
        tick();
        chk("t3_set_wins", spurious, 4'b0010);
        grant = 4'b0000;
        tick();
        clr_err = 1'b0;
        chk("t3_spur_cleared", spurious, 4'b0000);

        // Channel 3 holds 1 token. A push and a grant arrive in the same cycle.
        push = 4'b1000;
        tick();
        push = 4'b1000; grant = 4'b1000;
        tick();
        push = 4'b0000;
        chk("t4_done", done, 4'b1000);
        chk("t4_req_kept", req, 4'b1000);
        tick();
        grant = 4'b0000;
        chk("t4_done2", done, 4'b1000);
        chk("t4_req_low", req, 4'b0000);

        // While disabled, req is forced low and grants are ignored without a flag.
        en   = 1'b0;
        push = 4'b0001;
        tick();
        push = 4'b0000;
        chk("en0_req_low", req, 4'b0000);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        chk("en0_no_done", done, 4'b0000);
        chk("en0_no_spur", spurious, 4'b0000);
        en = 1'b1;
        #1;
        chk("en1_req_back", req, 4'b0001);

        // Keep req0 high with no grant. Starve appears after 100 waiting edges.
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 99) chk("wd_not_yet", starve, 4'b0000);
        end
        chk("wd_starve", starve, STARVE_EXP);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        chk("wd_cleared", starve, 4'b0000);
        chk("wd_done", done, 4'b0001);

        // Assert reset asynchronously, in mid-cycle, while all channels hold tokens.
        push = 4'b1111;
        tick();
        push = 4'b0000;
        chk("rst2_req_all", req, 4'b1111);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        chk("rst2_done_pre", done, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("rst2_req_async", req, 4'b0000);
        chk("rst2_done_async", done, 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        chk("rst2_req_after", req, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
